// File: rtl/pc_gen_ras.sv
// pc_gen_ras -- IF-stage next-PC generator with a circular return-address stack.
//
// Next PC is chosen by fixed priority (first match wins):
//   0 trap in M, 1 mispredict not-taken in M, 2 mispredict taken in M,
//   3 late register-jump in E, 4 D-stage return predicted by RAS,
//   5 D-stage jump, 6 D-stage predicted-taken branch, 7 sequential.
// D-stage calls push pc_plus8_d; D-stage returns pop it back as the target.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   -> pc_misalign_f is a flop loaded with (next_pc[1:0] != 0)
//                together with pc (fetch-side AdEL source).
//   undefined -> pc_misalign_f is tied to 0.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   stall_f              hold pc (RAS updates still commit)
//   d_fire               D-stage instruction advances to E this cycle
//   trap_m, pc_exception_m                 M-stage exception redirect
//   mispred_m, actual_take_m, pc_branch_m, pc_plus8_m  M-stage branch repair
//   jump_conflict_e, pc_jump_e             E-stage late jump redirect
//   jump_d, jump_conflict_d, pc_jump_d     D-stage jump
//   branch_d, pred_take_d, pc_branch_d     D-stage predicted branch
//   call_d, ret_d, pc_plus8_d              RAS push / pop controls and data
//   pc_plus4_f           sequential next PC
//   pc                   current fetch PC
//   ras_hit_d            return redirected by the RAS this cycle
//   redirect_src         selected source code 0..7
//   ras_count            number of valid RAS entries
//   pc_misalign_f        fetch PC misaligned (see macro above)
module pc_gen_ras #(
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   RESET_PC  = AW'(32'hbfc0_0000),
  parameter int              RAS_DEPTH = 8,
  parameter int              RAS_PW    = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_f,
  input  logic              d_fire,
  input  logic              trap_m,
  input  logic [AW-1:0]     pc_exception_m,
  input  logic              mispred_m,
  input  logic              actual_take_m,
  input  logic [AW-1:0]     pc_branch_m,
  input  logic [AW-1:0]     pc_plus8_m,
  input  logic              jump_conflict_e,
  input  logic [AW-1:0]     pc_jump_e,
  input  logic              jump_d,
  input  logic              jump_conflict_d,
  input  logic [AW-1:0]     pc_jump_d,
  input  logic              branch_d,
  input  logic              pred_take_d,
  input  logic [AW-1:0]     pc_branch_d,
  input  logic              call_d,
  input  logic              ret_d,
  input  logic [AW-1:0]     pc_plus8_d,
  input  logic [AW-1:0]     pc_plus4_f,
  output logic [AW-1:0]     pc,
  output logic              ras_hit_d,
  output logic [2:0]        redirect_src,
  output logic [RAS_PW:0]   ras_count,
  output logic              pc_misalign_f
);

  localparam logic [2:0] SRC_TRAP    = 3'd0;
  localparam logic [2:0] SRC_MP_NT   = 3'd1;
  localparam logic [2:0] SRC_MP_T    = 3'd2;
  localparam logic [2:0] SRC_JMP_E   = 3'd3;
  localparam logic [2:0] SRC_RAS     = 3'd4;
  localparam logic [2:0] SRC_JMP_D   = 3'd5;
  localparam logic [2:0] SRC_BR_D    = 3'd6;
  localparam logic [2:0] SRC_SEQ     = 3'd7;

  localparam logic [RAS_PW-1:0] PTR_ONE  = RAS_PW'(1);
  localparam logic [RAS_PW:0]   CNT_ONE  = (RAS_PW+1)'(1);
  localparam logic [RAS_PW:0]   CNT_FULL = (RAS_PW+1)'(RAS_DEPTH);

  logic [AW-1:0]     ras_mem [RAS_DEPTH];
  logic [RAS_PW-1:0] ras_ptr;
  logic [RAS_PW-1:0] ptr_top;
  logic [RAS_PW:0]   cnt;
  logic [AW-1:0]     ras_top;
  logic              ras_empty;

  logic [AW-1:0]     next_pc;
  logic [2:0]        src;

  logic              flush;
  logic              kill;
  logic              commit;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;

  // ptr always points at the next free slot; the top entry sits just below it.
  assign ptr_top   = ras_ptr - PTR_ONE;
  assign ras_top   = ras_mem[ptr_top];
  assign ras_empty = (cnt == '0);

  // Next-PC selection
  always_comb begin
    src     = SRC_SEQ;
    next_pc = pc_plus4_f;
    if (trap_m) begin
      src     = SRC_TRAP;
      next_pc = pc_exception_m;
    end else if (mispred_m && !actual_take_m) begin
      src     = SRC_MP_NT;
      next_pc = pc_plus8_m;
    end else if (mispred_m && actual_take_m) begin
      src     = SRC_MP_T;
      next_pc = pc_branch_m;
    end else if (jump_conflict_e) begin
      src     = SRC_JMP_E;
      next_pc = pc_jump_e;
    end else if (ret_d && !ras_empty) begin
      src     = SRC_RAS;
      next_pc = ras_top;
    end else if (jump_d && !jump_conflict_d) begin
      src     = SRC_JMP_D;
      next_pc = pc_jump_d;
    end else if (branch_d && pred_take_d) begin
      src     = SRC_BR_D;
      next_pc = pc_branch_d;
    end
  end

  assign redirect_src = src;
  assign ras_hit_d    = (src == SRC_RAS);
  assign ras_count    = cnt;

  // RAS update control. A call+ret pair on a non-empty stack pops then pushes,
  // which collapses to overwriting the top entry in place. On an empty stack
  // the pop is a no-op, so the pair degenerates into a plain push.
  assign flush      = trap_m | mispred_m;
  assign kill       = flush | jump_conflict_e;
  assign commit     = d_fire & ~kill;
  assign do_replace = commit & call_d & ret_d & ~ras_empty;
  assign do_push    = commit & call_d & ~do_replace;
  assign do_pop     = commit & ret_d & ~call_d & ~ras_empty;

  // RAS pointer/count registers (stall_f does not gate these)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr <= '0;
      cnt     <= '0;
    end else if (flush) begin
      ras_ptr <= '0;
      cnt     <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_ONE;
      cnt     <= (cnt == CNT_FULL) ? CNT_FULL : cnt + CNT_ONE;
    end else if (do_pop) begin
      ras_ptr <= ptr_top;
      cnt     <= cnt - CNT_ONE;
    end
  end

  // RAS storage: data only, no reset. A full push wraps onto the oldest entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_ptr] <= pc_plus8_d;
    end else if (do_replace) begin
      ras_mem[ptr_top] <= pc_plus8_d;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc <= RESET_PC;
    end else if (!stall_f) begin
      pc <= next_pc;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_misalign_f <= 1'b0;
    end else if (!stall_f) begin
      pc_misalign_f <= (next_pc[1:0] != 2'b00);
    end
  end
`else
  assign pc_misalign_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  localparam int AW = 32;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;
  localparam logic [31:0] SEQ_PC = 32'h0000_5000;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          stall_f, d_fire, trap_m, mispred_m, actual_take_m;
  logic          jump_conflict_e, jump_d, jump_conflict_d, branch_d, pred_take_d;
  logic          call_d, ret_d;
  logic [AW-1:0] pc_exception_m, pc_branch_m, pc_plus8_m, pc_jump_e;
  logic [AW-1:0] pc_jump_d, pc_branch_d, pc_plus8_d, pc_plus4_f;
  logic [AW-1:0] pc;
  logic          ras_hit_d;
  logic [2:0]    redirect_src;
  logic [3:0]    ras_count;
  logic          pc_misalign_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen_ras dut (
    .clk(clk), .resetn(resetn), .stall_f(stall_f), .d_fire(d_fire),
    .trap_m(trap_m), .pc_exception_m(pc_exception_m),
    .mispred_m(mispred_m), .actual_take_m(actual_take_m),
    .pc_branch_m(pc_branch_m), .pc_plus8_m(pc_plus8_m),
    .jump_conflict_e(jump_conflict_e), .pc_jump_e(pc_jump_e),
    .jump_d(jump_d), .jump_conflict_d(jump_conflict_d), .pc_jump_d(pc_jump_d),
    .branch_d(branch_d), .pred_take_d(pred_take_d), .pc_branch_d(pc_branch_d),
    .call_d(call_d), .ret_d(ret_d), .pc_plus8_d(pc_plus8_d),
    .pc_plus4_f(pc_plus4_f), .pc(pc), .ras_hit_d(ras_hit_d),
    .redirect_src(redirect_src), .ras_count(ras_count),
    .pc_misalign_f(pc_misalign_f)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    stall_f = 0; d_fire = 0; trap_m = 0; mispred_m = 0; actual_take_m = 0;
    jump_conflict_e = 0; jump_d = 0; jump_conflict_d = 0; branch_d = 0;
    pred_take_d = 0; call_d = 0; ret_d = 0;
    pc_exception_m = 32'hbfc0_0380; pc_branch_m = 32'h0000_8100;
    pc_plus8_m = 32'h0000_8008; pc_jump_e = 32'h0000_8200;
    pc_jump_d = 32'h0000_8300; pc_branch_d = 32'h0000_8400;
    pc_plus8_d = 32'h0; pc_plus4_f = SEQ_PC;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] ra);
    idle();
    call_d = 1; d_fire = 1; pc_plus8_d = ra;
    tick();
  endtask

  task automatic test_reset();
    resetn = 0;
    idle();
    tick(); tick();
    checks++;
    if (pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_PC); end
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++;
    if (pc_misalign_f !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", pc_misalign_f); end
    resetn = 1;
    tick();
    idle(); jump_d = 1; pc_jump_d = 32'h0000_3000;
    tick();
    checks++;
    if (pc !== 32'h0000_3000) begin failures++; $display("FAIL pre_reset_jump got=%h exp=00003000", pc); end
    push(32'h0000_0abc);
    checks++;
    if (ras_count !== 4'd1) begin failures++; $display("FAIL pre_reset_count got=%0d exp=1", ras_count); end
    // asynchronous reset between clock edges
    idle();
    #3 resetn = 0;
    #1;
    checks++;
    if (pc !== RST_PC) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", pc, RST_PC); end
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", ras_count); end
    #2 resetn = 1;
    tick();
  endtask

  task automatic test_trap_priority();
    push(32'h0000_0700);
    checks++;
    if (ras_count !== 4'd1) begin failures++; $display("FAIL trap_pre_count got=%0d exp=1", ras_count); end
    idle();
    trap_m = 1; mispred_m = 1; actual_take_m = 1; jump_conflict_e = 1;
    jump_d = 1; ret_d = 1; call_d = 1; d_fire = 1; branch_d = 1; pred_take_d = 1;
    pc_plus8_d = 32'h0000_0900;
    #1;
    checks++;
    if (redirect_src !== 3'd0) begin failures++; $display("FAIL trap_src got=%0d exp=0", redirect_src); end
    checks++;
    if (ras_hit_d !== 1'b0) begin failures++; $display("FAIL trap_hit got=%b exp=0", ras_hit_d); end
    tick();
    checks++;
    if (pc !== 32'hbfc0_0380) begin failures++; $display("FAIL trap_pc got=%h exp=bfc00380", pc); end
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL trap_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_priority_chain();
    logic [31:0] exp_pc;
    for (int k = 1; k <= 7; k++) begin
      if (k != 4) begin
        idle();
        mispred_m = (k <= 2); actual_take_m = (k == 2);
        jump_conflict_e = (k <= 3); jump_d = (k <= 5);
        branch_d = 1; pred_take_d = (k <= 6);
        case (k)
          1: exp_pc = 32'h0000_8008;
          2: exp_pc = 32'h0000_8100;
          3: exp_pc = 32'h0000_8200;
          5: exp_pc = 32'h0000_8300;
          6: exp_pc = 32'h0000_8400;
          default: exp_pc = SEQ_PC;
        endcase
        #1;
        checks++;
        if (redirect_src !== 3'(k)) begin failures++; $display("FAIL chain_src k=%0d got=%0d exp=%0d", k, redirect_src, k); end
        tick();
        checks++;
        if (pc !== exp_pc) begin failures++; $display("FAIL chain_pc k=%0d got=%h exp=%h", k, pc, exp_pc); end
      end
    end
    // jump with target not yet available falls through to the branch predictor
    idle(); jump_d = 1; jump_conflict_d = 1; branch_d = 1; pred_take_d = 1;
    #1;
    checks++;
    if (redirect_src !== 3'd6) begin failures++; $display("FAIL jconf_d_src got=%0d exp=6", redirect_src); end
    tick();
  endtask

  task automatic test_ras_lifo();
    logic [31:0] exp_pc;
    push(32'h0000_0100); push(32'h0000_0200); push(32'h0000_0300);
    checks++;
    if (ras_count !== 4'd3) begin failures++; $display("FAIL lifo_count got=%0d exp=3", ras_count); end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0000_0300 - 32'(i) * 32'h100;
      idle(); ret_d = 1; d_fire = 1;
      #1;
      checks++;
      if (ras_hit_d !== 1'b1 || redirect_src !== 3'd4) begin
        failures++; $display("FAIL lifo_hit i=%0d hit=%b src=%0d exp hit=1 src=4", i, ras_hit_d, redirect_src);
      end
      tick();
      checks++;
      if (pc !== exp_pc) begin failures++; $display("FAIL lifo_pc i=%0d got=%h exp=%h", i, pc, exp_pc); end
    end
    idle(); ret_d = 1; d_fire = 1; jump_d = 1; pc_jump_d = 32'h0000_0400;
    #1;
    checks++;
    if (redirect_src !== 3'd5 || ras_hit_d !== 1'b0) begin
      failures++; $display("FAIL empty_ret src=%0d hit=%b exp src=5 hit=0", redirect_src, ras_hit_d);
    end
    tick();
    checks++;
    if (pc !== 32'h0000_0400) begin failures++; $display("FAIL empty_ret_pc got=%h exp=00000400", pc); end
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL empty_ret_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 9; i++) push(32'(i) * 32'h10);
    checks++;
    if (ras_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", ras_count); end
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'h90 - 32'(i) * 32'h10;
      idle(); ret_d = 1; d_fire = 1;
      tick();
      checks++;
      if (pc !== exp_pc) begin failures++; $display("FAIL ovf_pop i=%0d got=%h exp=%h", i, pc, exp_pc); end
    end
    idle(); ret_d = 1; d_fire = 1;
    #1;
    checks++;
    if (ras_hit_d !== 1'b0 || redirect_src !== 3'd7) begin
      failures++; $display("FAIL ovf_ninth hit=%b src=%0d exp hit=0 src=7", ras_hit_d, redirect_src);
    end
    tick();
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL ovf_final_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_kill_stall();
    push(32'h0000_0a00);
    idle(); call_d = 1; d_fire = 1; jump_conflict_e = 1;
    pc_jump_e = 32'h0000_2000; pc_plus8_d = 32'h0000_0b00;
    #1;
    checks++;
    if (redirect_src !== 3'd3) begin failures++; $display("FAIL kill_src got=%0d exp=3", redirect_src); end
    tick();
    checks++;
    if (pc !== 32'h0000_2000) begin failures++; $display("FAIL kill_pc got=%h exp=00002000", pc); end
    checks++;
    if (ras_count !== 4'd1) begin failures++; $display("FAIL kill_count got=%0d exp=1", ras_count); end
    idle(); stall_f = 1; ret_d = 1; d_fire = 1;
    #1;
    checks++;
    if (ras_hit_d !== 1'b1) begin failures++; $display("FAIL stall_ret_hit got=%b exp=1", ras_hit_d); end
    tick();
    checks++;
    if (pc !== 32'h0000_2000) begin failures++; $display("FAIL stall_hold_pc got=%h exp=00002000", pc); end
    checks++;
    if (ras_count !== 4'd0) begin failures++; $display("FAIL stall_pop_count got=%0d exp=0", ras_count); end
    // flush under stall: pc holds, RAS clears
    push(32'h0000_0c00);
    idle(); stall_f = 1; mispred_m = 1; actual_take_m = 1; pc_branch_m = 32'h0000_9000;
    tick();
    checks++;
    if (pc !== SEQ_PC || ras_count !== 4'd0) begin
      failures++; $display("FAIL stall_flush pc=%h count=%0d exp pc=%h count=0", pc, ras_count, SEQ_PC);
    end
  endtask

  task automatic test_call_ret_pair();
    push(32'h0000_0111);
    idle(); call_d = 1; ret_d = 1; d_fire = 1; pc_plus8_d = 32'h0000_0222;
    #1;
    checks++;
    if (redirect_src !== 3'd4) begin failures++; $display("FAIL pair_src got=%0d exp=4", redirect_src); end
    tick();
    checks++;
    if (pc !== 32'h0000_0111 || ras_count !== 4'd1) begin
      failures++; $display("FAIL pair_replace pc=%h count=%0d exp pc=00000111 count=1", pc, ras_count);
    end
    idle(); ret_d = 1; d_fire = 1;
    tick();
    checks++;
    if (pc !== 32'h0000_0222 || ras_count !== 4'd0) begin
      failures++; $display("FAIL pair_pop pc=%h count=%0d exp pc=00000222 count=0", pc, ras_count);
    end
    idle(); call_d = 1; ret_d = 1; d_fire = 1; pc_plus8_d = 32'h0000_0333;
    tick();
    checks++;
    if (ras_count !== 4'd1) begin failures++; $display("FAIL pair_empty_push got=%0d exp=1", ras_count); end
    idle(); ret_d = 1; d_fire = 1;
    tick();
    checks++;
    if (pc !== 32'h0000_0333) begin failures++; $display("FAIL pair_empty_pop got=%h exp=00000333", pc); end
  endtask

  task automatic test_misalign();
    idle(); jump_d = 1; pc_jump_d = 32'h0000_1002;
    tick();
    checks++;
    if (pc !== 32'h0000_1002 || pc_misalign_f !== MIS_EXP) begin
      failures++; $display("FAIL misalign pc=%h flag=%b exp pc=00001002 flag=%b", pc, pc_misalign_f, MIS_EXP);
    end
    idle();
    tick();
    checks++;
    if (pc !== SEQ_PC || pc_misalign_f !== 1'b0) begin
      failures++; $display("FAIL aligned pc=%h flag=%b exp pc=%h flag=0", pc, pc_misalign_f, SEQ_PC);
    end
  endtask

  initial begin
    test_reset();
    test_trap_priority();
    test_priority_chain();
    test_ras_lifo();
    test_overflow();
    test_kill_stall();
    test_call_ret_pair();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
